// File: rtl/counter_mon_pkg.sv
// -----------------------------------------------------------------------------
// counter_mon_pkg
// Shared types and default parameter values for the counter sequence monitor.
//   cmon_state_t : monitor FSM state (IDLE -> SYNC -> LOCKED)
//   CMON_*       : default values for the counter_monitor parameters
// -----------------------------------------------------------------------------
package counter_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } cmon_state_t;

  localparam int CMON_WIDTH      = 4;
  localparam int CMON_LOCK_CNT   = 3;
  localparam int CMON_ERR_CNT_W  = 8;
  localparam int CMON_WRAP_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Parameterised saturating up-counter with asynchronous active-low reset and a
// synchronous clear that takes priority over increment.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear
//   i_inc   : increment by one; holds at all-ones
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_monitor.sv
// -----------------------------------------------------------------------------
// counter_monitor
// Sequence checker for a free-running WIDTH-bit counter. Locks onto the
// increment-by-one sequence, pulses err on any break while locked, and keeps
// a saturating error count and a modulo wrap count.
//
// Optional build macro: COUNTER_MON_CAPTURE_EN adds first-error capture of the
// expected and observed values (cap_expected / cap_observed).
//
// Ports:
//   clk          : rising-edge clock (same as the observed counter)
//   clr          : asynchronous active-low reset
//   q            : observed counter value
//   sample_en    : qualifies q on this edge
//   dut_clr      : counter clear in effect; suppresses checking, expected -> 0
//   locked       : sequence tracked for >= LOCK_CNT consecutive increments
//   err          : one-cycle pulse per sequence break while locked
//   err_sticky   : set on first err, cleared only by clr
//   err_count    : saturating count of err pulses
//   wrap_count   : locked all-ones -> 0 transitions, modulo 2^WRAP_CNT_W
//   cap_expected : expected value at first error (macro only)
//   cap_observed : observed value at first error (macro only)
// -----------------------------------------------------------------------------
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int WIDTH      = CMON_WIDTH,
  parameter int LOCK_CNT   = CMON_LOCK_CNT,
  parameter int ERR_CNT_W  = CMON_ERR_CNT_W,
  parameter int WRAP_CNT_W = CMON_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      q,
  input  logic                  sample_en,
  input  logic                  dut_clr,
  output logic                  locked,
  output logic                  err,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
`ifdef COUNTER_MON_CAPTURE_EN
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      cap_expected,
  output logic [WIDTH-1:0]      cap_observed
`else
  output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

  localparam int SYNC_W = $clog2(LOCK_CNT + 1);
  // A match seen while sync_cnt already holds LOCK_CNT-1 is the lock-making one.
  localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(LOCK_CNT - 1);

  cmon_state_t           r_state;
  logic [WIDTH-1:0]      r_expected;
  logic                  r_prev_max;
  logic                  r_locked;
  logic                  r_err;
  logic                  r_err_sticky;
  logic [WRAP_CNT_W-1:0] r_wrap_count;
  logic [SYNC_W-1:0]     w_sync_cnt;

  logic                  w_check;
  logic                  w_match;
  logic [WIDTH-1:0]      w_q_inc;
  logic                  w_err_event;
  logic                  w_wrap_event;
  logic                  w_sync_inc;
  logic                  w_sync_clr;

  // A qualified, non-cleared sample is the only thing that gets compared.
  assign w_check      = sample_en & ~dut_clr;
  assign w_match      = (q == r_expected);
  assign w_q_inc      = q + WIDTH'(1);
  assign w_err_event  = w_check && (r_state == LOCKED) && !w_match;
  assign w_wrap_event = w_check && (r_state == LOCKED) && w_match &&
                        (q == '0) && r_prev_max;
  assign w_sync_inc   = w_check && (r_state == SYNC) && w_match;
  assign w_sync_clr   = w_check && ((r_state == IDLE) ||
                                    ((r_state == SYNC) && !w_match) ||
                                    w_err_event);

  sat_counter #(.W(SYNC_W)) u_sync_cnt (
    .clk     (clk),
    .rst_n   (clr),
    .i_clr   (w_sync_clr),
    .i_inc   (w_sync_inc),
    .o_count (w_sync_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (clr),
    .i_clr   (1'b0),
    .i_inc   (w_err_event),
    .o_count (err_count)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= IDLE;
      r_expected   <= '0;
      r_prev_max   <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      // err is a pulse: it falls on the next edge whether or not q is sampled.
      r_err <= w_err_event;
      if (sample_en) begin
        r_prev_max <= (q == '1);
        if (dut_clr) begin
          r_expected <= '0;
        end else begin
          // Every compared sample, match or not, re-seeds the expectation.
          r_expected <= w_q_inc;
          case (r_state)
            IDLE: begin
              r_state <= SYNC;
            end
            SYNC: begin
              if (w_match && (w_sync_cnt == LAST_SYNC)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end
            LOCKED: begin
              if (!w_match) begin
                r_state  <= SYNC;
                r_locked <= 1'b0;
              end
            end
            default: begin
              r_state  <= IDLE;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
      if (w_err_event) begin
        r_err_sticky <= 1'b1;
      end
      if (w_wrap_event) begin
        r_wrap_count <= r_wrap_count + WRAP_CNT_W'(1);
      end
    end
  end

`ifdef COUNTER_MON_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_expected;
  logic [WIDTH-1:0] r_cap_observed;

  // err_sticky still low means this is the first error since reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cap_expected <= '0;
      r_cap_observed <= '0;
    end else if (w_err_event && !r_err_sticky) begin
      r_cap_expected <= r_expected;
      r_cap_observed <= q;
    end
  end

  assign cap_expected = r_cap_expected;
  assign cap_observed = r_cap_observed;
`endif

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_counter_monitor.sv
// -----------------------------------------------------------------------------
// tb_counter_monitor
// Directed testbench for counter_monitor (WIDTH=4, LOCK_CNT=3, ERR_CNT_W=2).
// Build with +define+COUNTER_MON_CAPTURE_EN to also exercise the capture ports.
// -----------------------------------------------------------------------------
module tb_counter_monitor;

  localparam int WIDTH      = 4;
  localparam int LOCK_CNT   = 3;
  localparam int ERR_CNT_W  = 2;
  localparam int WRAP_CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  clr;
  logic [WIDTH-1:0]      q;
  logic                  sample_en;
  logic                  dut_clr;
  logic                  locked;
  logic                  err;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
`ifdef COUNTER_MON_CAPTURE_EN
  logic [WIDTH-1:0]      cap_expected;
  logic [WIDTH-1:0]      cap_observed;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  counter_monitor #(
    .WIDTH      (WIDTH),
    .LOCK_CNT   (LOCK_CNT),
    .ERR_CNT_W  (ERR_CNT_W),
    .WRAP_CNT_W (WRAP_CNT_W)
  ) u_dut (
    .clk          (clk),
    .clr          (clr),
    .q            (q),
    .sample_en    (sample_en),
    .dut_clr      (dut_clr),
    .locked       (locked),
    .err          (err),
    .err_sticky   (err_sticky),
    .err_count    (err_count),
`ifdef COUNTER_MON_CAPTURE_EN
    .wrap_count   (wrap_count),
    .cap_expected (cap_expected),
    .cap_observed (cap_observed)
`else
    .wrap_count   (wrap_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one edge worth of inputs, then look at outputs 1 time unit after it.
  task automatic cyc(input logic [WIDTH-1:0] qv, input logic en, input logic dc);
    q         = qv;
    sample_en = en;
    dut_clr   = dc;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] b;

  initial begin
    clr       = 1'b0;
    q         = '0;
    sample_en = 1'b0;
    dut_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_wrap", wrap_count, 0);
    @(negedge clk);
    clr = 1'b1;

    // Clean count 0..15, 0, 1: lock after q=3, one wrap after second q=0.
    for (int i = 0; i < 18; i++) begin
      cyc(WIDTH'(i), 1'b1, 1'b0);
      chk("s1_err", err, 0);
      if (i == 2)  chk("s1_unlocked_q2", locked, 0);
      if (i == 3)  chk("s1_locked_q3", locked, 1);
      if (i == 15) chk("s1_wrap_before", wrap_count, 0);
      if (i == 16) chk("s1_wrap_after", wrap_count, 1);
    end
    chk("s1_errcnt", err_count, 0);
    chk("s1_sticky", err_sticky, 0);

    // Break: 2..5 then 7.
    for (int v = 2; v <= 5; v++) cyc(WIDTH'(v), 1'b1, 1'b0);
    chk("s2_pre_err", err, 0);
    cyc(4'd7, 1'b1, 1'b0);
    chk("s2_err", err, 1);
    chk("s2_errcnt", err_count, 1);
    chk("s2_sticky", err_sticky, 1);
    chk("s2_unlock", locked, 0);
`ifdef COUNTER_MON_CAPTURE_EN
    chk("s2_cap_exp", cap_expected, 6);
    chk("s2_cap_obs", cap_observed, 7);
`endif
    cyc(4'd8, 1'b1, 1'b0);
    chk("s2_err_pulse", err, 0);
    chk("s2_sync8", locked, 0);
    cyc(4'd9, 1'b1, 1'b0);
    chk("s2_sync9", locked, 0);
    cyc(4'd10, 1'b1, 1'b0);
    chk("s2_relock", locked, 1);
    chk("s2_errcnt_hold", err_count, 1);

    // Five more lock/break cycles: 2-bit err_count must stop at 3.
    e = 4'd11;
    for (int k = 0; k < 5; k++) begin
      b = e + 4'd5;
      cyc(b, 1'b1, 1'b0);
      chk("s3_err", err, 1);
      chk("s3_errcnt", err_count, (k + 2 > 3) ? 3 : k + 2);
      chk("s3_unlock", locked, 0);
      if (k == 0) begin
        cyc(b, 1'b0, 1'b0);
        chk("s3_err_fall_noen", err, 0);
        chk("s3_errcnt_noen", err_count, 2);
      end
      cyc(b + 4'd1, 1'b1, 1'b0);
      chk("s3_err_fall", err, 0);
      cyc(b + 4'd2, 1'b1, 1'b0);
      cyc(b + 4'd3, 1'b1, 1'b0);
      chk("s3_relock", locked, 1);
      e = b + 4'd4;
    end
    chk("s3_sticky", err_sticky, 1);
    chk("s3_wrap_hold", wrap_count, 1);
`ifdef COUNTER_MON_CAPTURE_EN
    chk("s3_cap_exp_hold", cap_expected, 6);
    chk("s3_cap_obs_hold", cap_observed, 7);
`endif

    // Locked at q=9, then dut_clr with an unrelated q, then 0,1,2.
    cyc(4'd8, 1'b1, 1'b0);
    cyc(4'd9, 1'b1, 1'b0);
    chk("s4_locked9", locked, 1);
    cyc(4'd12, 1'b1, 1'b1);
    chk("s4_clr_err", err, 0);
    chk("s4_clr_locked", locked, 1);
    for (int v = 0; v < 3; v++) begin
      cyc(WIDTH'(v), 1'b1, 1'b0);
      chk("s4_err", err, 0);
      chk("s4_locked", locked, 1);
    end
    cyc(4'd7, 1'b0, 1'b0);
    chk("s4_noen_err", err, 0);
    chk("s4_noen_locked", locked, 1);
    cyc(4'd3, 1'b1, 1'b0);
    chk("s4_resume_err", err, 0);
    chk("s4_errcnt", err_count, 3);

    // Asynchronous clr between edges.
    #2;
    clr = 1'b0;
    #1;
    chk("s6_locked", locked, 0);
    chk("s6_sticky", err_sticky, 0);
    chk("s6_errcnt", err_count, 0);
    chk("s6_wrap", wrap_count, 0);
`ifdef COUNTER_MON_CAPTURE_EN
    chk("s6_cap_exp", cap_expected, 0);
    chk("s6_cap_obs", cap_observed, 0);
`endif
    @(negedge clk);
    clr = 1'b1;

    // sample_en toggling with q held on the low cycles: lock on 3rd match.
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0);
    chk("s5_err1", err, 0);
    cyc(4'd1, 1'b0, 1'b0);
    cyc(4'd2, 1'b1, 1'b0);
    chk("s5_unlocked2", locked, 0);
    cyc(4'd2, 1'b0, 1'b0);
    chk("s5_unlocked_hold", locked, 0);
    chk("s5_err2", err, 0);
    cyc(4'd3, 1'b1, 1'b0);
    chk("s5_locked3", locked, 1);
    chk("s5_err3", err, 0);
    chk("s5_errcnt", err_count, 0);
    chk("s5_sticky", err_sticky, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
